// File: rtl/jtag_bitbang_bridge_mc_pkg.sv
// Command/response encodings and command classifier for the multi-chain
// remote_bitbang JTAG bridge.
`timescale 1ns/1ps
package jtag_bridge_pkg;

  localparam logic [7:0] CMD_BLINK_ON  = 8'h42;  // 'B'
  localparam logic [7:0] CMD_BLINK_OFF = 8'h62;  // 'b'
  localparam logic [7:0] CMD_PIN_LO    = 8'h30;  // '0'
  localparam logic [7:0] CMD_PIN_HI    = 8'h37;  // '7'
  localparam logic [7:0] CMD_RST_LO    = 8'h72;  // 'r'
  localparam logic [7:0] CMD_RST_HI    = 8'h75;  // 'u'
  localparam logic [7:0] CMD_READ      = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STATUS    = 8'h3F;  // '?'
  localparam logic [7:0] CMD_SEL_MASK  = 8'h80;

  localparam logic [7:0] RESP_ZERO = 8'h30;      // "0"
  localparam logic [7:0] RESP_ONE  = 8'h31;      // "1"

  typedef enum logic [2:0] {
    CLS_NOP, CLS_LED, CLS_PINS, CLS_RST, CLS_READ, CLS_SEL, CLS_STATUS
  } cmd_cls_e;

  // Range check on the select index is left to the bridge, which knows NUM_CHAINS.
  function automatic cmd_cls_e cmd_class(input logic [7:0] b);
    if ((b & CMD_SEL_MASK) != 8'h00)                  return CLS_SEL;
    if (b == CMD_BLINK_ON || b == CMD_BLINK_OFF)      return CLS_LED;
    if (b >= CMD_PIN_LO && b <= CMD_PIN_HI)           return CLS_PINS;
    if (b >= CMD_RST_LO && b <= CMD_RST_HI)           return CLS_RST;
    if (b == CMD_READ)                                return CLS_READ;
    if (b == CMD_STATUS)                              return CLS_STATUS;
    return CLS_NOP;
  endfunction

endpackage

// File: rtl/jtag_bitbang_bridge_mc_if.sv
// USB byte-stream handshake bundle between the CDC endpoints and the bridge.
// Signal suffixes are from the bridge's point of view.
`timescale 1ns/1ps
interface jtag_bitbang_bridge_mc_if;
  logic [7:0] from_usb_data_i;
  logic       from_usb_valid_i;
  logic       from_usb_ready_o;
  logic [7:0] to_usb_data_o;
  logic       to_usb_valid_o;
  logic       to_usb_ready_i;

  modport master (
    output from_usb_data_i, from_usb_valid_i, to_usb_ready_i,
    input  from_usb_ready_o, to_usb_data_o, to_usb_valid_o
  );

  modport slave (
    input  from_usb_data_i, from_usb_valid_i, to_usb_ready_i,
    output from_usb_ready_o, to_usb_data_o, to_usb_valid_o
  );
endinterface

// File: rtl/jtag_bitbang_bridge_mc_resp_fifo.sv
// jtag_resp_fifo: synchronous show-ahead FIFO. Pointers carry one extra wrap
// bit; full/empty come from comparing it. Head reads as zero while empty.
`timescale 1ns/1ps
module jtag_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointers and storage; push and pop may both fire in one cycle.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = data_i;
      wr_d = wr_q + 1'b1;
    end
    if (pop_ok) rd_d = rd_q + 1'b1;
  end

  // Pointer and storage registers; reset drops anything queued.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/jtag_bitbang_bridge_mc.sv
// jtag_bitbang_bridge_mc: remote_bitbang byte decoder driving NUM_CHAINS JTAG
// chains with queued TDO responses. Optional '?' status byte is built when
// JTAG_BRIDGE_STATUS_EN is defined.
`timescale 1ns/1ps
module jtag_bitbang_bridge_mc
  import jtag_bridge_pkg::*;
#(
  parameter int NUM_CHAINS  = 2,
  parameter int RESP_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  jtag_bitbang_bridge_mc_if.slave usb,
  output logic [NUM_CHAINS-1:0] tck_o,
  output logic [NUM_CHAINS-1:0] tms_o,
  output logic [NUM_CHAINS-1:0] tdi_o,
  input  logic [NUM_CHAINS-1:0] tdo_i,
  output logic                  trst_o,
  output logic                  srst_o,
  output logic                  bitbang_led_o,
  output logic [SEL_W-1:0]      chain_sel_o
);
  logic [NUM_CHAINS-1:0]                  tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [SYNC_STAGES-1:0][NUM_CHAINS-1:0] sync_q, sync_d;
  logic [SEL_W-1:0]                       sel_q, sel_d;
  logic                                   trst_q, trst_d, srst_q, srst_d, led_q, led_d;
  logic                                   accept, fifo_full, fifo_empty, push;
  logic [7:0]                             push_data, cmd;
  cmd_cls_e                               cls;

  assign cmd        = usb.from_usb_data_i;
  assign cls        = cmd_class(cmd);
  // Back-pressure every command while full so order is never broken.
  assign usb.from_usb_ready_o = !fifo_full;
  assign accept     = usb.from_usb_valid_i && !fifo_full;
  assign usb.to_usb_valid_o   = !fifo_empty;

  assign tck_o         = tck_q;
  assign tms_o         = tms_q;
  assign tdi_o         = tdi_q;
  assign trst_o        = trst_q;
  assign srst_o        = srst_q;
  assign bitbang_led_o = led_q;
  assign chain_sel_o   = sel_q;

  // Command decode: next pin/reset/LED/select state and response push.
  always_comb begin
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    trst_d    = trst_q;
    srst_d    = srst_q;
    led_d     = led_q;
    sel_d     = sel_q;
    push      = 1'b0;
    push_data = RESP_ZERO;
    sync_d    = {sync_q[SYNC_STAGES-2:0], tdo_i};
    if (accept) begin
      unique case (cls)
        CLS_LED:  led_d = (cmd == CMD_BLINK_ON);
        CLS_PINS: begin
          for (int c = 0; c < NUM_CHAINS; c++) begin
            if (int'(sel_q) == c) {tck_d[c], tms_d[c], tdi_d[c]} = cmd[2:0];
          end
        end
        // 'r'..'u' have low bits 10,11,00,01; adding 2 maps them to 00..11.
        CLS_RST:  {trst_d, srst_d} = cmd[1:0] + 2'b10;
        CLS_READ: begin
          push      = 1'b1;
          push_data = sync_q[SYNC_STAGES-1][sel_q] ? RESP_ONE : RESP_ZERO;
        end
        CLS_SEL:  if (int'(cmd[6:0]) < NUM_CHAINS) sel_d = cmd[SEL_W-1:0];
`ifdef JTAG_BRIDGE_STATUS_EN
        CLS_STATUS: begin
          logic [3:0] sel4;
          sel4            = '0;
          sel4[SEL_W-1:0] = sel_q;
          push            = 1'b1;
          push_data       = {1'b0, fifo_full, 2'b00, sel4};
        end
`endif
        default: ;
      endcase
    end
  end

  // Pin, control and synchronizer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tck_q  <= '0;
      tms_q  <= '0;
      tdi_q  <= '0;
      trst_q <= 1'b0;
      srst_q <= 1'b0;
      led_q  <= 1'b0;
      sel_q  <= '0;
      sync_q <= '0;
    end else begin
      tck_q  <= tck_d;
      tms_q  <= tms_d;
      tdi_q  <= tdi_d;
      trst_q <= trst_d;
      srst_q <= srst_d;
      led_q  <= led_d;
      sel_q  <= sel_d;
      sync_q <= sync_d;
    end
  end

  jtag_resp_fifo #(.WIDTH(8), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (usb.to_usb_ready_i),
    .data_o  (usb.to_usb_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_jtag_bitbang_bridge_mc.sv
// Directed bench for jtag_bitbang_bridge_mc (NUM_CHAINS=2, RESP_DEPTH=8).
`timescale 1ns/1ps
module tb_jtag_bitbang_bridge_mc;
  localparam int NC = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [NC-1:0] tck_o, tms_o, tdi_o, tdo_i;
  logic          trst_o, srst_o, bitbang_led_o;
  logic [0:0]    chain_sel_o;

  int         n_vec = 0, n_miss = 0;
  logic [7:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  jtag_bitbang_bridge_mc_if u_if();

  jtag_bitbang_bridge_mc #(.NUM_CHAINS(NC), .RESP_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .usb           (u_if),
    .tck_o         (tck_o),
    .tms_o         (tms_o),
    .tdi_o         (tdi_o),
    .tdo_i         (tdo_i),
    .trst_o        (trst_o),
    .srst_o        (srst_o),
    .bitbang_led_o (bitbang_led_o),
    .chain_sel_o   (chain_sel_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle once the bridge is ready (bounded wait).
  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk_i);
    while (!u_if.from_usb_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (t == 20) chk("send_ready", 32'(u_if.from_usb_ready_o), 32'd1);
    u_if.from_usb_data_i  = b;
    u_if.from_usb_valid_i = 1'b1;
    @(negedge clk_i);
    u_if.from_usb_valid_i = 1'b0;
  endtask

  // Set chain1 TDO, let it cross the synchronizer, then issue 'R'.
  task automatic read_r(input logic v);
    tdo_i[1] = v;
    repeat (3) @(negedge clk_i);
    send(8'h52);
    exp_q.push_back(v ? 8'h31 : 8'h30);
  endtask

  task automatic drain(input int n, input string tag);
    u_if.to_usb_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(u_if.to_usb_valid_o), 32'd1);
      chk({tag, "_data"}, 32'(u_if.to_usb_data_o), 32'(exp_q.pop_front()));
      @(negedge clk_i);
    end
    u_if.to_usb_ready_i = 1'b0;
    chk({tag, "_empty"}, 32'(u_if.to_usb_valid_o), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    u_if.from_usb_data_i  = 8'h00;
    u_if.from_usb_valid_i = 1'b0;
    u_if.to_usb_ready_i   = 1'b0;
    tdo_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_pins", 32'({tck_o, tms_o, tdi_o, trst_o, srst_o, bitbang_led_o, chain_sel_o}), 32'd0);
    chk("rst_valid", 32'(u_if.to_usb_valid_o), 32'd0);
    chk("rst_data", 32'(u_if.to_usb_data_o), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 32'(u_if.from_usb_ready_o), 32'd1);

    // '5' -> chain0 {tck,tms,tdi}=101, chain1 untouched
    send(8'h35);
    chk("p5_tck", 32'(tck_o), 32'b01);
    chk("p5_tms", 32'(tms_o), 32'b00);
    chk("p5_tdi", 32'(tdi_o), 32'b01);
    chk("p5_valid", 32'(u_if.to_usb_valid_o), 32'd0);

    // select chain1, '6' -> chain1=110, then R with tdo=10
    send(8'h81);
    chk("sel1", 32'(chain_sel_o), 32'd1);
    send(8'h36);
    chk("p6_tck", 32'(tck_o), 32'b11);
    chk("p6_tms", 32'(tms_o), 32'b10);
    chk("p6_tdi", 32'(tdi_o), 32'b01);
    tdo_i = 2'b10;
    repeat (3) @(negedge clk_i);
    send(8'h52);
    chk("r_valid", 32'(u_if.to_usb_valid_o), 32'd1);
    chk("r_data", 32'(u_if.to_usb_data_o), 32'h31);
    u_if.to_usb_ready_i = 1'b1;
    @(negedge clk_i);
    u_if.to_usb_ready_i = 1'b0;
    chk("r_popped", 32'(u_if.to_usb_valid_o), 32'd0);

    // out-of-range select, resets, LED, unknown byte
    send(8'h85);
    chk("sel_oor", 32'(chain_sel_o), 32'd1);
    send(8'h74);
    chk("rst_t", 32'({trst_o, srst_o}), 32'b10);
    send(8'h73);
    chk("rst_s", 32'({trst_o, srst_o}), 32'b01);
    send(8'h75);
    chk("rst_u", 32'({trst_o, srst_o}), 32'b11);
    send(8'h72);
    chk("rst_r", 32'({trst_o, srst_o}), 32'b00);
    send(8'h42);
    chk("led_on", 32'(bitbang_led_o), 32'd1);
    send(8'h62);
    chk("led_off", 32'(bitbang_led_o), 32'd0);
    send(8'h78);
    chk("nop_pins", 32'({tck_o, tms_o, tdi_o}), 32'b11_10_01);
    chk("nop_valid", 32'(u_if.to_usb_valid_o), 32'd0);

    // fill to full, ninth R must stall
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      chk("fill_ready", 32'(u_if.from_usb_ready_o), 32'd1);
      read_r(pat[i]);
    end
    chk("full_ready", 32'(u_if.from_usb_ready_o), 32'd0);
    u_if.from_usb_data_i  = 8'h52;
    u_if.from_usb_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("stall_ready", 32'(u_if.from_usb_ready_o), 32'd0);
    u_if.from_usb_valid_i = 1'b0;
    drain(8, "drain8");

    // simultaneous push+pop at level 7
    pat = 8'b0110_1001;
    for (int i = 0; i < 7; i++) read_r(pat[i]);
    chk("lvl7_ready", 32'(u_if.from_usb_ready_o), 32'd1);
    tdo_i[1] = 1'b1;
    repeat (3) @(negedge clk_i);
    u_if.from_usb_data_i  = 8'h52;
    u_if.from_usb_valid_i = 1'b1;
    u_if.to_usb_ready_i   = 1'b1;
    @(negedge clk_i);
    u_if.from_usb_valid_i = 1'b0;
    u_if.to_usb_ready_i   = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h31);
    chk("pp_ready", 32'(u_if.from_usb_ready_o), 32'd1);
    drain(7, "drain7");

    // reset in the middle of a drain
    send(8'h42);
    for (int i = 0; i < 3; i++) read_r(1'b1);
    u_if.to_usb_ready_i = 1'b1;
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(u_if.to_usb_valid_o), 32'd0);
    chk("mid_rst_data", 32'(u_if.to_usb_data_o), 32'd0);
    chk("mid_rst_pins", 32'({tck_o, tms_o, tdi_o, trst_o, srst_o, bitbang_led_o, chain_sel_o}), 32'd0);
    exp_q.delete();
    u_if.to_usb_ready_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_valid", 32'(u_if.to_usb_valid_o), 32'd0);
    chk("post_rst_ready", 32'(u_if.from_usb_ready_o), 32'd1);

    // status byte after selecting chain1
    send(8'h81);
    send(8'h3F);
`ifdef JTAG_BRIDGE_STATUS_EN
    chk("status_valid", 32'(u_if.to_usb_valid_o), 32'd1);
    chk("status_data", 32'(u_if.to_usb_data_o), 32'h01);
`else
    chk("status_ignored", 32'(u_if.to_usb_valid_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
